// File: rtl/dmem_resp_ctrl_if.sv
// Cache-side handshake bundle between the load/store arbiter (master)
// and the data-memory responder (slave).
interface dmem_resp_ctrl_if;
    logic        enable;
    logic        rd_wrt_ca;
    logic [15:0] addr_ca;
    logic [15:0] data_ca_in;
    logic        flush;
    logic        idle;
    logic        done;
    logic [15:0] data_ca_out;

    modport master (
        output enable,
        output rd_wrt_ca,
        output addr_ca,
        output data_ca_in,
        output flush,
        input  idle,
        input  done,
        input  data_ca_out
    );

    modport slave (
        input  enable,
        input  rd_wrt_ca,
        input  addr_ca,
        input  data_ca_in,
        input  flush,
        output idle,
        output done,
        output data_ca_out
    );
endinterface

// File: rtl/dmem_resp_ctrl.sv
// Data-memory responder: one word access at a time through a direct-mapped,
// write-through, no-write-allocate cache in front of a local backing array.
module dmem_resp_ctrl #(
    parameter int unsigned MEM_AW   = 10,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned HIT_LAT  = 1,
    parameter int unsigned MISS_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    dmem_resp_ctrl_if.slave  bus
);

    localparam int unsigned NumLines = 1 << IDX_W;
    localparam int unsigned MemWords = 1 << MEM_AW;
    localparam int unsigned TagW     = MEM_AW - IDX_W;
    localparam int unsigned CntW     = $clog2(MISS_LAT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                op_wr_q, op_wr_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    fidx_q, fidx_d;
    logic [NumLines-1:0] valid_q, valid_d;

    // Storage arrays carry no reset; contents survive rst.
    logic [15:0]         mem       [MemWords];
    logic [15:0]         line_data [NumLines];
    logic [TagW-1:0]     line_tag  [NumLines];

    logic                mem_we;
    logic                line_we;
    logic [15:0]         line_wdata;

    logic [IDX_W-1:0]    idx_in;
    logic [TagW-1:0]     tag_in;
    logic                hit_in;
    logic [IDX_W-1:0]    idx_cur;
    logic [TagW-1:0]     tag_cur;
    logic [15:0]         mem_rdata;

    // Upper address bits alias onto the backing array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_ca[15:MEM_AW];

    assign idx_in    = bus.addr_ca[IDX_W-1:0];
    assign tag_in    = bus.addr_ca[MEM_AW-1:IDX_W];
    assign hit_in    = valid_q[idx_in] && (line_tag[idx_in] == tag_in);
    assign idx_cur   = addr_q[IDX_W-1:0];
    assign tag_cur   = addr_q[MEM_AW-1:IDX_W];
    assign mem_rdata = mem[addr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        fidx_d     = fidx_q;
        valid_d    = valid_q;
        mem_we     = 1'b0;
        line_we    = 1'b0;
        line_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.flush) begin
                    // Flush wins; a same-cycle command is dropped.
                    state_d = StFlush;
                    fidx_d  = '0;
                end else if (bus.enable) begin
                    op_wr_d = bus.rd_wrt_ca;
                    addr_d  = bus.addr_ca[MEM_AW-1:0];
                    wdata_d = bus.data_ca_in;
                    hit_d   = hit_in;
                    cnt_d   = (!bus.rd_wrt_ca && hit_in) ? CntW'(HIT_LAT) : CntW'(MISS_LAT);
                    state_d = StBusy;
                end
            end

            StBusy: begin
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                if (done_q) begin
                    // Done cycle stays in BUSY so done never shows with idle.
                    state_d = (pend_q || bus.flush) ? StFlush : StIdle;
                    fidx_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        done_d = 1'b1;
                        if (op_wr_q) begin
                            mem_we = 1'b1;
                            if (hit_q) begin
                                line_we    = 1'b1;
                                line_wdata = wdata_q;
                            end
                        end else if (hit_q) begin
                            rdata_d = line_data[idx_cur];
                        end else begin
                            rdata_d          = mem_rdata;
                            line_we          = 1'b1;
                            line_wdata       = mem_rdata;
                            valid_d[idx_cur] = 1'b1;
                        end
                    end
                end
            end

            StFlush: begin
                valid_d[fidx_q] = 1'b0;
                fidx_d          = fidx_q + 1'b1;
                if (fidx_q == IDX_W'(NumLines - 1)) begin
                    state_d = StIdle;
                    pend_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 16'h0000;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            hit_q   <= 1'b0;
            fidx_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            fidx_q  <= fidx_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
        if (line_we) begin
            line_data[idx_cur] <= line_wdata;
            line_tag[idx_cur]  <= tag_cur;
        end
    end

    assign bus.idle        = (state_q == StIdle);
    assign bus.done        = done_q;
    assign bus.data_ca_out = rdata_q;

    done_only_in_busy: assert property (@(posedge clk) disable iff (rst)
        done_q |-> (state_q == StBusy));

    cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CntW'(MISS_LAT));

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Directed bench for dmem_resp_ctrl: latency, hit/miss, no-allocate,
// tag conflicts, flush in IDLE and BUSY, and reset abort.
module tb_dmem_resp_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    dmem_resp_ctrl_if bus ();

    dmem_resp_ctrl #(
        .MEM_AW   (10),
        .IDX_W    (3),
        .HIT_LAT  (1),
        .MISS_LAT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Issue one command; flush is raised for one cycle after sample flush_at.
    task automatic do_op(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input int flush_at, output int lat, output logic [15:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.idle && n < 50) begin
            n++;
            @(negedge clk);
        end
        bus.enable     = 1'b1;
        bus.rd_wrt_ca  = wr;
        bus.addr_ca    = a;
        bus.data_ca_in = d;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            bus.flush = (lat == flush_at);
        end
        bus.flush = 1'b0;
        rd = bus.data_ca_out;
    endtask

    task automatic run(input string name, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input int flush_at, input int exp_lat,
                       input logic [15:0] exp_data);
        int          lat;
        logic [15:0] rd;
        do_op(wr, a, d, flush_at, lat, rd);
        check({name, " latency"}, lat, exp_lat);
        if (!wr) check({name, " data"}, {16'h0, rd}, {16'h0, exp_data});
    endtask

    // Count cycles with idle low starting at the next edge.
    task automatic wait_idle(output int n, output bit saw_done);
        n = 0;
        saw_done = 1'b0;
        @(posedge clk);
        #1;
        while (!bus.idle && n < 40) begin
            if (bus.done) saw_done = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        bit saw;

        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.rd_wrt_ca  = 1'b0;
        bus.addr_ca    = 16'h0;
        bus.data_ca_in = 16'h0;
        bus.flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset idle", {31'h0, bus.idle}, 32'd1);
        check("reset done", {31'h0, bus.done}, 32'd0);
        check("reset data", {16'h0, bus.data_ca_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write, miss read, hit read
        run("wr 0012",    1'b1, 16'h0012, 16'hBEEF, -1, 4, 16'h0);
        run("rd 0012 m",  1'b0, 16'h0012, 16'h0,    -1, 4, 16'hBEEF);
        run("rd 0012 h",  1'b0, 16'h0012, 16'h0,    -1, 1, 16'hBEEF);

        // Write to a resident line; no-allocate on a conflicting write miss
        run("wr 0005 a",  1'b1, 16'h0005, 16'h0A0A, -1, 4, 16'h0);
        run("rd 0005 m",  1'b0, 16'h0005, 16'h0,    -1, 4, 16'h0A0A);
        run("wr 0005 b",  1'b1, 16'h0005, 16'h1234, -1, 4, 16'h0);
        run("rd 0005 h",  1'b0, 16'h0005, 16'h0,    -1, 1, 16'h1234);
        run("wr 000D",    1'b1, 16'h000D, 16'h5555, -1, 4, 16'h0);
        run("rd 0005 h2", 1'b0, 16'h0005, 16'h0,    -1, 1, 16'h1234);
        run("rd 000D m",  1'b0, 16'h000D, 16'h0,    -1, 4, 16'h5555);

        // Tag conflict on index 3
        run("wr 0003",    1'b1, 16'h0003, 16'h3333, -1, 4, 16'h0);
        run("wr 000B",    1'b1, 16'h000B, 16'hBBBB, -1, 4, 16'h0);
        run("rd 0003 m",  1'b0, 16'h0003, 16'h0,    -1, 4, 16'h3333);
        run("rd 000B m",  1'b0, 16'h000B, 16'h0,    -1, 4, 16'hBBBB);
        run("rd 0003 m2", 1'b0, 16'h0003, 16'h0,    -1, 4, 16'h3333);

        // Flush in IDLE with a same-cycle write that must be dropped
        run("rd 0012 h2", 1'b0, 16'h0012, 16'h0,    -1, 1, 16'hBEEF);
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.enable     = 1'b1;
        bus.rd_wrt_ca  = 1'b1;
        bus.addr_ca    = 16'h0012;
        bus.data_ca_in = 16'hDEAD;
        wait_idle(n, saw);
        bus.flush  = 1'b0;
        bus.enable = 1'b0;
        check("idle flush len", n, 8);
        check("idle flush done", {31'h0, saw}, 32'd0);
        run("rd 0012 pf", 1'b0, 16'h0012, 16'h0,    -1, 4, 16'hBEEF);

        // Flush pulsed during a read miss
        run("rd 000B bf", 1'b0, 16'h000B, 16'h0,     1, 4, 16'hBBBB);
        wait_idle(n, saw);
        check("busy flush len", n, 8);
        check("busy flush done", {31'h0, saw}, 32'd0);
        run("rd 0012 bf", 1'b0, 16'h0012, 16'h0,    -1, 4, 16'hBEEF);
        run("rd 0003 bf", 1'b0, 16'h0003, 16'h0,    -1, 4, 16'h3333);

        // Reset in cycle 2 of a read miss
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.rd_wrt_ca = 1'b0;
        bus.addr_ca   = 16'h000B;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", {31'h0, bus.done}, 32'd0);
        check("abort idle", {31'h0, bus.idle}, 32'd1);
        check("abort data", {16'h0, bus.data_ca_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.done) saw = 1'b1;
        end
        check("abort no done", {31'h0, saw}, 32'd0);

        // Valid bits cleared by reset, backing array kept; upper bits alias
        run("rd 0003 pr", 1'b0, 16'h0003, 16'h0,    -1, 4, 16'h3333);
        run("rd 0412 al", 1'b0, 16'h0412, 16'h0,    -1, 4, 16'hBEEF);
        run("rd 0012 al", 1'b0, 16'h0012, 16'h0,    -1, 1, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
